// File: rtl/pc_predict_unit.sv
// Fetch-stage PC unit: holds the fetch PC, computes the fall-through
// address and predicts the next PC. Jumps are predicted taken, CALL goes
// to valC, and RET pops a circular return-address stack. A back-end
// redirect overrides everything except reset and flushes the stack.
module pc_predict_unit #(
    parameter int                  DATA_WID  = 64,
    parameter logic [DATA_WID-1:0] RESET_PC  = '0,
    parameter int                  RAS_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        stall,
    input  logic [3:0]                  icode,
    input  logic [DATA_WID-1:0]         valC,
    input  logic                        redir_valid,
    input  logic [DATA_WID-1:0]         redir_pc,
    output logic [DATA_WID-1:0]         f_pc,
    output logic [DATA_WID-1:0]         f_valP,
    output logic [DATA_WID-1:0]         f_pred_pc,
    output logic                        f_valid,
    output logic                        f_bad_icode,
    output logic [$clog2(RAS_DEPTH):0]  ras_count
);

    localparam int WB = DATA_WID / 8;
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [DATA_WID-1:0] LEN_1    = DATA_WID'(1);
    localparam logic [DATA_WID-1:0] LEN_2    = DATA_WID'(2);
    localparam logic [DATA_WID-1:0] LEN_REG  = DATA_WID'(2 + WB);
    localparam logic [DATA_WID-1:0] LEN_DEST = DATA_WID'(1 + WB);
    localparam logic [CW-1:0]       RAS_FULL = CW'(RAS_DEPTH);

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_RET = 2'd1,
        HALTED   = 2'd2
    } state_t;

    state_t                             state, state_n;
    logic [DATA_WID-1:0]                pc_n;
    logic [DATA_WID-1:0]                len;
    logic [RAS_DEPTH-1:0][DATA_WID-1:0] ras_mem;
    logic [PW-1:0]                      ras_tp, ras_tp_n;
    logic [CW-1:0]                      cnt_n;
    logic                               ras_we;
    logic [DATA_WID-1:0]                ras_top;

    assign ras_top = ras_mem[ras_tp];

    // Instruction length decode; unknown icodes advance by one byte.
    always_comb begin
        len = LEN_1;
        case (icode)
            4'h0, 4'h1, 4'h9:       len = LEN_1;
            4'h2, 4'h6, 4'hA, 4'hB: len = LEN_2;
            4'h3, 4'h4, 4'h5:       len = LEN_REG;
            4'h7, 4'h8:             len = LEN_DEST;
            default:                len = LEN_1;
        endcase
    end

    assign f_valP = f_pc + len;

    // Next-PC prediction: jumps always taken, RET uses the stack top when one exists.
    always_comb begin
        f_pred_pc = f_valP;
        case (icode)
            I_JXX, I_CALL: f_pred_pc = valC;
            I_RET:         f_pred_pc = (ras_count != '0) ? ras_top : f_pc;
            I_HALT:        f_pred_pc = f_pc;
            default:       f_pred_pc = f_valP;
        endcase
    end

    // State, PC and stack pointer/count registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            f_pc      <= RESET_PC;
            ras_tp    <= '0;
            ras_count <= '0;
        end else begin
            state     <= state_n;
            f_pc      <= pc_n;
            ras_tp    <= ras_tp_n;
            ras_count <= cnt_n;
        end
    end

    // Stack storage needs no reset; entries are only read below ras_count.
    always_ff @(posedge CLK) begin
        if (ras_we) ras_mem[ras_tp_n] <= f_valP;
    end

    // Next-state: redirect > stall > normal; only RUN advances the PC.
    always_comb begin
        state_n  = state;
        pc_n     = f_pc;
        ras_tp_n = ras_tp;
        cnt_n    = ras_count;
        ras_we   = 1'b0;
        if (redir_valid) begin
            // Speculative pushes/pops can't be trusted after a redirect.
            state_n = RUN;
            pc_n    = redir_pc;
            cnt_n   = '0;
        end else if (!stall && state == RUN) begin
            case (icode)
                I_CALL: begin
                    // Full stack overwrites the oldest entry; count saturates.
                    ras_we   = 1'b1;
                    ras_tp_n = ras_tp + 1'b1;
                    cnt_n    = (ras_count == RAS_FULL) ? ras_count : ras_count + 1'b1;
                    pc_n     = valC;
                end
                I_RET: begin
                    if (ras_count != '0) begin
                        ras_tp_n = ras_tp - 1'b1;
                        cnt_n    = ras_count - 1'b1;
                        pc_n     = ras_top;
                    end else begin
                        state_n = WAIT_RET;
                    end
                end
                I_HALT:  state_n = HALTED;
                default: pc_n = f_pred_pc;
            endcase
        end
    end

    // Outputs: fetch is real only in RUN; bad icode flagged only then.
    always_comb begin
        f_valid     = (state == RUN);
        f_bad_icode = (state == RUN) && (icode >= 4'hC);
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit (DATA_WID=64, RESET_PC=0x100, RAS_DEPTH=4).
module tb_pc_predict_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall;
    logic [3:0]  icode;
    logic [63:0] valC;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic [63:0] f_pc, f_valP, f_pred_pc;
    logic        f_valid, f_bad_icode;
    logic [2:0]  ras_count;

    int total = 0;
    int bad   = 0;

    pc_predict_unit #(.DATA_WID(64), .RESET_PC(64'h100), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .stall(stall), .icode(icode), .valC(valC),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .f_pc(f_pc),
        .f_valP(f_valP), .f_pred_pc(f_pred_pc), .f_valid(f_valid),
        .f_bad_icode(f_bad_icode), .ras_count(ras_count)
    );

    always #5 CLK = ~CLK;

    // Inputs for this cycle plus expected pre-edge outputs.
    typedef struct {
        logic        st;
        logic [3:0]  ic;
        logic [63:0] vc;
        logic        rv;
        logic [63:0] rp;
        logic [63:0] pc;
        logic [63:0] vp;
        logic [63:0] pr;
        logic        vl;
        logic        bd;
        logic [2:0]  cn;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic st, input logic [3:0] ic, input logic [63:0] vc,
                         input logic rv, input logic [63:0] rp);
        stall = st; icode = ic; valC = vc; redir_valid = rv; redir_pc = rp;
    endtask

    task automatic redirect(input logic [63:0] pc);
        drive(0, 4'h1, 0, 1, pc);
        tick();
    endtask

    initial begin
        // stall icode valC redir redir_pc | f_pc valP pred valid bad cnt
        vecs.push_back('{0, 4'h1, 0,     0, 0,     64'h100, 64'h101, 64'h101, 1, 0, 0});
        vecs.push_back('{0, 4'h6, 0,     0, 0,     64'h101, 64'h103, 64'h103, 1, 0, 0});
        vecs.push_back('{0, 4'h3, 0,     0, 0,     64'h103, 64'h10D, 64'h10D, 1, 0, 0});
        vecs.push_back('{0, 4'h2, 0,     0, 0,     64'h10D, 64'h10F, 64'h10F, 1, 0, 0});
        vecs.push_back('{0, 4'h1, 0,     1, 64'h200, 64'h10F, 64'h110, 64'h110, 1, 0, 0});
        vecs.push_back('{0, 4'h7, 64'h400, 0, 0,   64'h200, 64'h209, 64'h400, 1, 0, 0});
        vecs.push_back('{0, 4'h8, 64'h800, 0, 0,   64'h400, 64'h409, 64'h800, 1, 0, 0});
        vecs.push_back('{0, 4'h9, 0,     0, 0,     64'h800, 64'h801, 64'h409, 1, 0, 1});
        vecs.push_back('{0, 4'h1, 0,     0, 0,     64'h409, 64'h40A, 64'h40A, 1, 0, 0});
        vecs.push_back('{0, 4'h8, 64'h600, 0, 0,   64'h40A, 64'h413, 64'h600, 1, 0, 0});
        vecs.push_back('{1, 4'h8, 64'h700, 0, 0,   64'h600, 64'h609, 64'h700, 1, 0, 1});
        vecs.push_back('{1, 4'h8, 64'h700, 0, 0,   64'h600, 64'h609, 64'h700, 1, 0, 1});
        vecs.push_back('{1, 4'h8, 64'h700, 0, 0,   64'h600, 64'h609, 64'h700, 1, 0, 1});
        vecs.push_back('{1, 4'h8, 64'h700, 1, 64'h55, 64'h600, 64'h609, 64'h700, 1, 0, 1});
        vecs.push_back('{0, 4'h0, 0,     0, 0,     64'h55,  64'h56,  64'h55,  1, 0, 0});
        vecs.push_back('{0, 4'h1, 0,     0, 0,     64'h55,  64'h56,  64'h56,  0, 0, 0});
        vecs.push_back('{0, 4'hE, 0,     1, 64'h10, 64'h55, 64'h56,  64'h56,  0, 0, 0});
        vecs.push_back('{0, 4'hE, 0,     0, 0,     64'h10,  64'h11,  64'h11,  1, 1, 0});
        vecs.push_back('{0, 4'h1, 0,     1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h11, 64'h12, 64'h12, 1, 0, 0});
        vecs.push_back('{0, 4'h1, 0,     0, 0,     64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1, 0, 0});
        vecs.push_back('{0, 4'h4, 0,     0, 0,     64'h0,   64'hA,   64'hA,   1, 0, 0});

        // Reset state
        RST = 1'b1;
        drive(0, 4'h1, 0, 0, 0);
        #2;
        chk("rst_pc", f_pc, 64'h100);
        chk("rst_cnt", 64'(ras_count), 0);
        chk("rst_valid", 64'(f_valid), 1);
        icode = 4'hD;
        #1;
        chk("rst_bad_icode", 64'(f_bad_icode), 1);
        icode = 4'h1;
        tick();
        tick();
        RST = 1'b0;

        // Table-driven vectors
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].ic, vecs[i].vc, vecs[i].rv, vecs[i].rp);
            #1;
            chk($sformatf("v%0d_pc", i),    f_pc, vecs[i].pc);
            chk($sformatf("v%0d_valP", i),  f_valP, vecs[i].vp);
            chk($sformatf("v%0d_pred", i),  f_pred_pc, vecs[i].pr);
            chk($sformatf("v%0d_valid", i), 64'(f_valid), 64'(vecs[i].vl));
            chk($sformatf("v%0d_bad", i),   64'(f_bad_icode), 64'(vecs[i].bd));
            chk($sformatf("v%0d_cnt", i),   64'(ras_count), 64'(vecs[i].cn));
            tick();
        end

        // RAS overflow: 5 nested calls, 4 predicted returns, 5th waits
        redirect(64'h1000);
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'h8, 64'((i + 2) << 12), 0, 0);
            #1;
            chk($sformatf("call%0d_pc", i), f_pc, 64'((i + 1) << 12));
            chk($sformatf("call%0d_cnt", i), 64'(ras_count), 64'((i < 4) ? i : 4));
            tick();
        end
        chk("ovf_cnt", 64'(ras_count), 4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 4'h9, 0, 0, 0);
            #1;
            chk($sformatf("ret%0d_pred", i), f_pred_pc, 64'(((5 - i) << 12) + 9));
            tick();
            chk($sformatf("ret%0d_cnt", i), 64'(ras_count), 64'(3 - i));
        end
        drive(0, 4'h9, 0, 0, 0);
        tick();
        chk("wret_valid", 64'(f_valid), 0);
        chk("wret_pc", f_pc, 64'h2009);
        tick();
        chk("wret_hold_pc", f_pc, 64'h2009);
        redirect(64'h1009);
        chk("wret_exit_pc", f_pc, 64'h1009);
        chk("wret_exit_valid", 64'(f_valid), 1);

        // Halt holds for 10 cycles, then redirect to 0
        redirect(64'h300);
        drive(0, 4'h0, 0, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 4'h1, 0, 0, 0);
            #1;
            chk($sformatf("halt%0d_pc", i), f_pc, 64'h300);
            chk($sformatf("halt%0d_valid", i), 64'(f_valid), 0);
            tick();
        end
        redirect(64'h0);
        chk("halt_exit_pc", f_pc, 64'h0);
        chk("halt_exit_valid", 64'(f_valid), 1);

        // Async reset while halted with two stacked returns
        redirect(64'h500);
        drive(0, 4'h8, 64'h600, 0, 0);
        tick();
        drive(0, 4'h8, 64'h700, 0, 0);
        tick();
        drive(0, 4'h0, 0, 0, 0);
        tick();
        drive(1, 4'h1, 0, 0, 0);
        #1;
        chk("pre_rst_cnt", 64'(ras_count), 2);
        chk("pre_rst_valid", 64'(f_valid), 0);
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_pc", f_pc, 64'h100);
        chk("async_rst_cnt", 64'(ras_count), 0);
        chk("async_rst_valid", 64'(f_valid), 1);
        @(negedge CLK);
        RST = 1'b0;
        drive(0, 4'h1, 0, 0, 0);
        tick();
        chk("post_rst_pc", f_pc, 64'h101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
